// File: rtl/huff_limit_codegen.sv
// Length-limited canonical Huffman code generator: it redistributes code-length counts
// above LIMIT, then assigns canonical codes to the symbols one per cycle.
module huff_limit_codegen #(
  parameter int unsigned SYMBOLS  = 6,
  parameter int unsigned MAX_BITS = 32,
  parameter int unsigned LIMIT    = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [8*MAX_BITS-1:0]    BITS_packed,
  input  logic [8*SYMBOLS-1:0]     HUFFMANVAL_packed,
  output logic                     busy,
  output logic                     done,
  output logic                     err,
  output logic [8*LIMIT-1:0]       BITS_out_packed,
  output logic [8*SYMBOLS-1:0]     HUFFSIZE_packed,
  output logic [LIMIT*SYMBOLS-1:0] HUFFMAN_CODE_packed
);

  localparam int unsigned IW = $clog2(MAX_BITS + 1);
  localparam int unsigned KW = (SYMBOLS > 1) ? $clog2(SYMBOLS) : 1;
  localparam int unsigned CW = LIMIT + 1;

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_ADJ_SCAN, S_ADJ_FIND, S_ADJ_APPLY, S_GEN, S_DONE
  } state_t;

  state_t r_state, w_state_nxt;

  logic [7:0]               r_bits [0:MAX_BITS];
  logic [8*SYMBOLS-1:0]     r_huffval;
  logic [IW-1:0]            r_i, r_j, r_len;
  logic [7:0]               r_cnt;
  logic [CW-1:0]            r_code;
  logic [KW-1:0]            r_k;
  logic                     r_err;
  logic [8*LIMIT-1:0]       r_bits_out;
  logic [8*SYMBOLS-1:0]     r_huffsize;
  logic [LIMIT*SYMBOLS-1:0] r_codes;

  logic [11:0]   w_sum;
  logic [7:0]    w_adj [0:MAX_BITS];
  logic [8:0]    w_inc1, w_inc2;
  logic          w_adj_ovf;
  logic          w_gen_found;
  logic [IW-1:0] w_gen_len;
  logic [CW-1:0] w_gen_code;
  logic          w_gen_kraft;
  logic          w_fail;

  always_comb begin
    w_sum = '0;
    for (int unsigned b = 1; b <= MAX_BITS; b++) w_sum = w_sum + 12'(r_bits[b]);
  end

  // The four updates are applied in order, so i-1 and j+1 may coincide.
  always_comb begin
    w_adj = r_bits;
    w_adj[r_i] = w_adj[r_i] - 8'd2;
    w_inc1 = {1'b0, w_adj[r_i - 1'b1]} + 9'd1;
    w_adj[r_i - 1'b1] = w_inc1[7:0];
    w_inc2 = {1'b0, w_adj[r_j + 1'b1]} + 9'd2;
    w_adj[r_j + 1'b1] = w_inc2[7:0];
    w_adj[r_j] = w_adj[r_j] - 8'd1;
    w_adj_ovf = w_inc1[8] | w_inc2[8];
  end

  // Smallest length that still has codes left; a descending loop lets the lowest match win.
  always_comb begin
    w_gen_found = 1'b0;
    w_gen_len   = r_len;
    for (int unsigned l = LIMIT; l >= 1; l--) begin
      if ((IW'(l) == r_len && r_cnt < r_bits[l]) ||
          (IW'(l) >  r_len && r_bits[l] != 8'd0)) begin
        w_gen_found = 1'b1;
        w_gen_len   = IW'(l);
      end
    end
    w_gen_code  = r_code << (w_gen_len - r_len);
    w_gen_kraft = (w_gen_code >= (CW'(1) << w_gen_len));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_fail      = 1'b0;
    unique case (r_state)
      S_IDLE: if (start) w_state_nxt = S_LOAD;
      S_LOAD: begin
        if (w_sum != 12'(SYMBOLS)) begin
          w_fail      = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ADJ_SCAN;
        end
      end
      S_ADJ_SCAN: begin
        if (r_i == IW'(LIMIT))          w_state_nxt = S_GEN;
        else if (r_bits[r_i] != 8'd0)   w_state_nxt = S_ADJ_FIND;
      end
      S_ADJ_FIND: begin
        if (r_bits[r_i] == 8'd0) begin
          w_state_nxt = S_ADJ_SCAN;
        end else if (r_bits[r_i] == 8'd1 || r_j == '0) begin
          w_fail      = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_bits[r_j] != 8'd0) begin
          w_state_nxt = S_ADJ_APPLY;
        end
      end
      S_ADJ_APPLY: begin
        if (w_adj_ovf) begin
          w_fail      = 1'b1;
          w_state_nxt = S_DONE;
        end else begin
          w_state_nxt = S_ADJ_FIND;
        end
      end
      S_GEN: begin
        if (!w_gen_found || w_gen_kraft) begin
          w_fail      = 1'b1;
          w_state_nxt = S_DONE;
        end else if (r_k == KW'(SYMBOLS - 1)) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (r_state)
      S_LOAD, S_ADJ_SCAN, S_ADJ_FIND, S_ADJ_APPLY, S_GEN: busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bits     <= '{default: '0};
      r_huffval  <= '0;
      r_i        <= '0;
      r_j        <= '0;
      r_len      <= '0;
      r_cnt      <= '0;
      r_code     <= '0;
      r_k        <= '0;
      r_err      <= 1'b0;
      r_bits_out <= '0;
      r_huffsize <= '0;
      r_codes    <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_bits[0] <= '0;
            for (int unsigned b = 1; b <= MAX_BITS; b++) r_bits[b] <= BITS_packed[8*(b-1) +: 8];
            r_huffval  <= HUFFMANVAL_packed;
            r_err      <= 1'b0;
            r_bits_out <= '0;
            r_huffsize <= '0;
            r_codes    <= '0;
          end
        end
        S_LOAD: begin
          r_i    <= IW'(MAX_BITS);
          r_len  <= IW'(1);
          r_cnt  <= '0;
          r_code <= '0;
          r_k    <= '0;
        end
        S_ADJ_SCAN: begin
          if (r_i != IW'(LIMIT)) begin
            if (r_bits[r_i] == 8'd0) r_i <= r_i - 1'b1;
            else                     r_j <= r_i - IW'(2);
          end
        end
        S_ADJ_FIND: begin
          if (r_bits[r_i] == 8'd0)      r_i <= r_i - 1'b1;
          else if (r_bits[r_j] == 8'd0) r_j <= r_j - 1'b1;
        end
        S_ADJ_APPLY: begin
          if (!w_adj_ovf) begin
            r_bits <= w_adj;
            r_j    <= r_i - IW'(2);
          end
        end
        S_GEN: begin
          if (w_gen_found && !w_gen_kraft) begin
            r_huffsize[8*r_k +: 8]      <= 8'(w_gen_len);
            r_codes[LIMIT*r_k +: LIMIT] <= w_gen_code[LIMIT-1:0];
            r_code <= w_gen_code + 1'b1;
            r_len  <= w_gen_len;
            r_cnt  <= (w_gen_len == r_len) ? r_cnt + 8'd1 : 8'd1;
            r_k    <= r_k + 1'b1;
          end
        end
        default: ;
      endcase
      if (w_fail) r_err <= 1'b1;
      if (w_state_nxt == S_DONE) begin
        for (int unsigned l = 1; l <= LIMIT; l++) r_bits_out[8*(l-1) +: 8] <= r_bits[l];
      end
    end
  end

  assign err                 = r_err;
  assign BITS_out_packed     = r_bits_out;
  assign HUFFSIZE_packed     = r_huffsize;
  assign HUFFMAN_CODE_packed = r_codes;

endmodule

// File: tb/tb_huff_limit_codegen.sv
// Scoreboard bench for huff_limit_codegen: it runs three parameterisations, and per-DUT
// monitors pop the expected results whenever done pulses.
module tb_huff_limit_codegen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic [2:0]   start;
  logic [255:0] bits_in;
  logic [47:0]  hv;

  logic a_busy, a_done, a_err; logic [127:0] a_bo; logic [47:0] a_sz; logic [95:0] a_cd;
  logic b_busy, b_done, b_err; logic [31:0]  b_bo; logic [47:0] b_sz; logic [23:0] b_cd;
  logic c_busy, c_done, c_err; logic [127:0] c_bo; logic [23:0] c_sz; logic [47:0] c_cd;

  huff_limit_codegen #(.SYMBOLS(6), .MAX_BITS(32), .LIMIT(16)) u_a (
    .clk(clk), .rst(rst), .start(start[0]), .BITS_packed(bits_in), .HUFFMANVAL_packed(hv),
    .busy(a_busy), .done(a_done), .err(a_err), .BITS_out_packed(a_bo),
    .HUFFSIZE_packed(a_sz), .HUFFMAN_CODE_packed(a_cd));

  huff_limit_codegen #(.SYMBOLS(6), .MAX_BITS(32), .LIMIT(4)) u_b (
    .clk(clk), .rst(rst), .start(start[1]), .BITS_packed(bits_in), .HUFFMANVAL_packed(hv),
    .busy(b_busy), .done(b_done), .err(b_err), .BITS_out_packed(b_bo),
    .HUFFSIZE_packed(b_sz), .HUFFMAN_CODE_packed(b_cd));

  huff_limit_codegen #(.SYMBOLS(3), .MAX_BITS(32), .LIMIT(16)) u_c (
    .clk(clk), .rst(rst), .start(start[2]), .BITS_packed(bits_in), .HUFFMANVAL_packed(hv[23:0]),
    .busy(c_busy), .done(c_done), .err(c_err), .BITS_out_packed(c_bo),
    .HUFFSIZE_packed(c_sz), .HUFFMAN_CODE_packed(c_cd));

  typedef struct {
    string        nm;
    logic         e;
    logic [127:0] bo;
    logic [47:0]  sz;
    logic [95:0]  cd;
  } exp_t;

  exp_t qa[$], qb[$], qc[$];
  exp_t ea, eb, ec;
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  localparam logic [255:0] A_OK   = 256'h040200;
  localparam logic [255:0] A_ERR  = 256'h1400000000;
  localparam logic [255:0] B_OK   = 256'h0201010101;
  localparam logic [255:0] B_JERR = 256'h0600000000;
  localparam logic [255:0] B_IERR = 256'h0102010101;
  localparam logic [255:0] C_KR   = 256'h03;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  task automatic cmp_res(input exp_t e, input logic er, input logic [127:0] bo,
                         input logic [47:0] sz, input logic [95:0] cd);
    chk({e.nm, ".err"},  128'(er), 128'(e.e));
    chk({e.nm, ".bits"}, bo, e.bo);
    chk({e.nm, ".size"}, 128'(sz), 128'(e.sz));
    chk({e.nm, ".code"}, 128'(cd), 128'(e.cd));
  endtask

  function automatic exp_t mk(input string nm, input logic e, input logic [127:0] bo,
                              input logic [47:0] sz, input logic [95:0] cd);
    exp_t r;
    r.nm = nm; r.e = e; r.bo = bo; r.sz = sz; r.cd = cd;
    return r;
  endfunction

  function automatic logic dn(input int unsigned d);
    case (d)
      0:       return a_done;
      1:       return b_done;
      default: return c_done;
    endcase
  endfunction

  always @(negedge clk) begin
    if (rst === 1'b1 && a_done === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL A.unexpected_done: got done=1, required no pending result");
      end else begin
        ea = qa.pop_front();
        cmp_res(ea, a_err, a_bo, a_sz, a_cd);
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && b_done === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL B.unexpected_done: got done=1, required no pending result");
      end else begin
        eb = qb.pop_front();
        cmp_res(eb, b_err, 128'(b_bo), b_sz, 96'(b_cd));
      end
    end
  end

  always @(negedge clk) begin
    if (rst === 1'b1 && c_done === 1'b1) begin
      if (qc.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL C.unexpected_done: got done=1, required no pending result");
      end else begin
        ec = qc.pop_front();
        cmp_res(ec, c_err, c_bo, 48'(c_sz), 96'(c_cd));
      end
    end
  end

  task automatic issue(input int unsigned d, input logic [255:0] b);
    @(negedge clk);
    bits_in  = b;
    start[d] = 1'b1;
    @(negedge clk);
    start[d] = 1'b0;
  endtask

  task automatic wait_done(input int unsigned d, input string nm);
    int unsigned c = 0;
    while (dn(d) !== 1'b1 && c < 300) begin
      @(negedge clk);
      c++;
    end
    if (dn(d) !== 1'b1) begin
      n_cmp++; n_bad++;
      $display("FAIL %s.timeout: got no done in %0d cycles, required done", nm, c);
    end
    @(negedge clk);
  endtask

  task automatic chk_zero_a(input string tag);
    chk({tag, ".busy"}, 128'(a_busy), 128'd0);
    chk({tag, ".done"}, 128'(a_done), 128'd0);
    chk({tag, ".err"},  128'(a_err),  128'd0);
    chk({tag, ".bits"}, a_bo,         128'd0);
    chk({tag, ".size"}, 128'(a_sz),   128'd0);
    chk({tag, ".code"}, 128'(a_cd),   128'd0);
  endtask

  initial begin
    int unsigned lat;
    rst     = 1'b0;
    start   = '0;
    bits_in = '0;
    hv      = 48'h464544434241;
    repeat (2) @(negedge clk);
    chk_zero_a("A.reset");
    chk("B.reset.busy", 128'(b_busy), 128'd0);
    chk("B.reset.code", 128'(b_cd),   128'd0);
    chk("C.reset.done", 128'(c_done), 128'd0);
    chk("C.reset.size", 128'(c_sz),   128'd0);
    rst = 1'b1;

    qa.push_back(mk("A.basic", 1'b0, 128'h040200, 48'h030303030202, 96'h000700060005000400010000));
    issue(0, A_OK);
    wait_done(0, "A.basic");

    qa.push_back(mk("A.sum_err", 1'b1, 128'h1400000000, 48'h0, 96'h0));
    @(negedge clk);
    bits_in  = A_ERR;
    start[0] = 1'b1;
    lat      = 0;
    do begin
      @(negedge clk);
      start[0] = 1'b0;
      lat++;
    end while (a_done !== 1'b1 && lat < 50);
    chk("A.sum_err.latency", 128'(lat), 128'd2);
    @(negedge clk);

    qb.push_back(mk("B.limit", 1'b0, 128'h04000101, 48'h040404040201, 96'hfedc20));
    issue(1, B_OK);
    wait_done(1, "B.limit");
    repeat (3) @(negedge clk);
    chk("B.hold.code", 128'(b_cd), 128'hfedc20);
    chk("B.hold.bits", 128'(b_bo), 128'h04000101);

    qb.push_back(mk("B.no_j", 1'b1, 128'h0, 48'h0, 96'h0));
    issue(1, B_JERR);
    wait_done(1, "B.no_j");

    qb.push_back(mk("B.odd_bin", 1'b1, 128'h02010101, 48'h0, 96'h0));
    issue(1, B_IERR);
    wait_done(1, "B.odd_bin");

    qc.push_back(mk("C.kraft", 1'b1, 128'h03, 48'h000101, 96'h000000010000));
    issue(2, C_KR);
    wait_done(2, "C.kraft");

    issue(0, A_OK);
    repeat (19) @(negedge clk);
    chk("A.midgen.busy", 128'(a_busy), 128'd1);
    rst = 1'b0;
    #1;
    chk_zero_a("A.rst_async");
    @(negedge clk);
    chk_zero_a("A.rst_held");
    rst = 1'b1;
    qa.push_back(mk("A.rerun", 1'b0, 128'h040200, 48'h030303030202, 96'h000700060005000400010000));
    issue(0, A_OK);
    wait_done(0, "A.rerun");

    qb.push_back(mk("B.dbl_start", 1'b0, 128'h04000101, 48'h040404040201, 96'hfedc20));
    issue(1, B_OK);
    repeat (3) @(negedge clk);
    chk("B.dbl_start.busy", 128'(b_busy), 128'd1);
    start[1] = 1'b1;
    @(negedge clk);
    start[1] = 1'b0;
    wait_done(1, "B.dbl_start");
    repeat (60) @(negedge clk);

    chk("A.queue_left", 128'(qa.size()), 128'd0);
    chk("B.queue_left", 128'(qb.size()), 128'd0);
    chk("C.queue_left", 128'(qc.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/huff_limit_codegen.md
HUFF_LIMIT_CODEGEN -- requirements
Module: huff_limit_codegen

Interface
REQ-001 SHALL have parameter SYMBOLS, default 6: number of symbols in HUFFMANVAL_packed.
REQ-002 SHALL have parameter MAX_BITS, default 32: number of input code-length bins.
REQ-003 SHALL have parameter LIMIT, default 16, legal range 2..MAX_BITS: maximum output code length and code width.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port start, input, 1 bit: one-cycle request, sampled in IDLE only.
REQ-007 SHALL have port BITS_packed, input, 8*MAX_BITS bits: byte L-1 holds the count of codes of length L.
REQ-008 SHALL have port HUFFMANVAL_packed, input, 8*SYMBOLS bits: byte i holds symbol i, listed in increasing code-length order.
REQ-009 SHALL have port busy, output, 1 bit: high from the cycle after start is accepted until done.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port err, output, 1 bit: error status, valid from done until the next accepted start.
REQ-012 SHALL have port BITS_out_packed, output, 8*LIMIT bits: adjusted length counts.
REQ-013 SHALL have port HUFFSIZE_packed, output, 8*SYMBOLS bits: code length of symbol i.
REQ-014 SHALL have port HUFFMAN_CODE_packed, output, LIMIT*SYMBOLS bits: code of symbol i, right-aligned and zero-extended.

Function
REQ-015 SHALL implement states IDLE, LOAD, ADJ_SCAN, ADJ_FIND, ADJ_APPLY, GEN, DONE.
REQ-016 SHALL leave IDLE only on start=1, moving to LOAD; start is ignored in all other states.
REQ-017 LOAD SHALL take 1 cycle: register BITS and HUFFMANVAL, clear err, clear all outputs to zero, set busy, and compute the 12-bit sum of all BITS.
REQ-018 Sum != SYMBOLS SHALL set err and go to DONE; there is no adjustment or generation in that case.
REQ-019 ADJ_SCAN SHALL step i from MAX_BITS down to LIMIT+1, one bin per cycle, and go to ADJ_FIND whenever BITS[i] > 0.
REQ-020 ADJ_FIND SHALL search j = i-2 downward, one bin per cycle, until BITS[j] > 0.
REQ-021 If the search reaches j = 0, or BITS[i] == 1, the block SHALL set err and go to DONE.
REQ-022 ADJ_APPLY SHALL take 1 cycle and perform, in order: BITS[i] -= 2; BITS[i-1] += 1; BITS[j+1] += 2; BITS[j] -= 1. It then returns to ADJ_FIND for the same i.
REQ-023 Counts SHALL be 8-bit; any increment past 255 SHALL set err and go to DONE.
REQ-024 After i reaches LIMIT, GEN SHALL run one symbol per cycle:
  - symbol k gets the next smallest length L with remaining count, and a code from a LIMIT+1-bit counter;
  - the counter starts at 0, increments after each assignment, and shifts left by 1 for each length step.
REQ-025 Code >= 2^L at assignment (Kraft overflow) SHALL set err and go to DONE; codes already written are kept.
REQ-026 DONE SHALL last 1 cycle: done=1, busy=0, BITS_out_packed = BITS[1..LIMIT]; then go to IDLE.
REQ-027 All outputs SHALL hold their values in IDLE until the next LOAD.
REQ-028 Worst-case latency from start to done SHALL be bounded by 2 + MAX_BITS + SYMBOLS + (adjustments × MAX_BITS) cycles.

Reset
REQ-029 While rst=0, the block SHALL be in IDLE with busy=0, done=0, err=0, and all packed outputs zero, regardless of the clock.
REQ-030 Reset asserted mid-operation SHALL abort immediately, leaving no partial outputs.
REQ-031 After rst deasserts, the first start SHALL be accepted no earlier than the next rising edge.

Verification
REQ-032 SYMBOLS=6, LIMIT=16, BITS[2]=2, BITS[3]=4 -> codes 00, 01, 100, 101, 110, 111; sizes 2,2,3,3,3,3; err=0.
REQ-033 SYMBOLS=6, LIMIT=4, BITS[1..5]=1,1,1,1,2 -> BITS_out 1,1,0,4; codes A=0, B=10, C=1100, D=1101, E=1110, F=1111; err=0.
REQ-034 SYMBOLS=6, BITS[5]=20 -> err=1 with a done pulse exactly 2 cycles after start is sampled; all codes zero.
REQ-035 SYMBOLS=3, BITS[1]=3 -> err=1; codes A=0 and B=1 written, C=0.
REQ-036 Assert rst=0 during GEN, then rerun REQ-032 -> outputs zero during reset; rerun results identical to REQ-032.
REQ-037 Pulse start again while busy=1 -> ignored; exactly one done pulse; results unchanged.
